// File: rtl/mips_exec_core.sv
// mips_exec_core: single-issue MIPS decode/execute/writeback core.
//   Instruction decoder, 32x32 register file, 32-bit ALU and optional HI/LO
//   product registers. Each rising edge retires the word on `instr`.
//   GPIO is reached through two COP0-style encodings under opcode 0x10.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset (clears GPRs, HI/LO, gpio_out)
//   instr    in  32  instruction executed this cycle (32'h0 = NOP)
//   gpio_in  in  32  sampled by GPIO-read (opcode 0x10, rs=0)
//   gpio_out out 32  registered, loaded by GPIO-write (opcode 0x10, rs=4)
//   alu_zero out  1  combinational, high when this cycle's ALU lo result is 0
//
// Build option: define MULT_EN to include mult/multu/mfhi/mflo and HI/LO.
// Without it mult/multu are NOPs and mfhi/mflo write 0.
module mips_exec_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        alu_zero
);

    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,  ALU_OR   = 4'd1,  ALU_XOR  = 4'd2,  ALU_NOR = 4'd3,
        ALU_ADD  = 4'd4,  ALU_SUB  = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_MULT = 4'd11,
        ALU_MULTU = 4'd12, ALU_LUI = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_HI, WB_LO, WB_GPIO} wb_sel_t;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];

    logic [31:0] regs [32];
    logic [31:0] rs_val, rt_val;

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rs_val = (rs == 5'd0) ? 32'h0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'h0 : regs[rt];

    // ---------------- decode ----------------
    alu_op_t alu_op;
    wb_sel_t wb_sel;
    logic    use_imm, sext, gpr_we, hilo_we, gpio_we;
    logic [4:0] dst;

    always_comb begin
        alu_op  = ALU_AND;
        wb_sel  = WB_ALU;
        use_imm = 1'b0;
        sext    = 1'b0;
        gpr_we  = 1'b0;
        hilo_we = 1'b0;
        gpio_we = 1'b0;
        dst     = rd;
        case (opcode)
            6'h00: begin
                gpr_we = 1'b1;
                case (funct)
                    6'h00: alu_op = ALU_SLL;
                    6'h02: alu_op = ALU_SRL;
                    6'h03: alu_op = ALU_SRA;
                    6'h20, 6'h21: alu_op = ALU_ADD;
                    6'h22, 6'h23: alu_op = ALU_SUB;
                    6'h24: alu_op = ALU_AND;
                    6'h25: alu_op = ALU_OR;
                    6'h26: alu_op = ALU_XOR;
                    6'h27: alu_op = ALU_NOR;
                    6'h2A: alu_op = ALU_SLT;
                    6'h2B: alu_op = ALU_SLTU;
                    6'h18: begin
                        alu_op = ALU_MULT;
                        gpr_we = 1'b0;
`ifdef MULT_EN
                        hilo_we = 1'b1;
`endif
                    end
                    6'h19: begin
                        alu_op = ALU_MULTU;
                        gpr_we = 1'b0;
`ifdef MULT_EN
                        hilo_we = 1'b1;
`endif
                    end
                    6'h10: wb_sel = WB_HI;
                    6'h12: wb_sel = WB_LO;
                    default: gpr_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin alu_op = ALU_ADD;  use_imm = 1'b1; sext = 1'b1; gpr_we = 1'b1; dst = rt; end
            6'h0A:        begin alu_op = ALU_SLT;  use_imm = 1'b1; sext = 1'b1; gpr_we = 1'b1; dst = rt; end
            6'h0B:        begin alu_op = ALU_SLTU; use_imm = 1'b1; sext = 1'b1; gpr_we = 1'b1; dst = rt; end
            6'h0C:        begin alu_op = ALU_AND;  use_imm = 1'b1; gpr_we = 1'b1; dst = rt; end
            6'h0D:        begin alu_op = ALU_OR;   use_imm = 1'b1; gpr_we = 1'b1; dst = rt; end
            6'h0E:        begin alu_op = ALU_XOR;  use_imm = 1'b1; gpr_we = 1'b1; dst = rt; end
            6'h0F:        begin alu_op = ALU_LUI;  gpr_we = 1'b1; dst = rt; end
            6'h10: begin
                if (rs == 5'd0) begin
                    gpr_we = 1'b1;
                    dst    = rt;
                    wb_sel = WB_GPIO;
                end else if (rs == 5'd4) begin
                    gpio_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- ALU ----------------
    logic [31:0] imm_ext, op_b, alu_lo;

    assign imm_ext = sext ? {{16{imm[15]}}, imm} : {16'h0, imm};
    assign op_b    = use_imm ? imm_ext : rt_val;

`ifdef MULT_EN
    logic [63:0] prod;
    logic [31:0] hi_q, lo_q;
`endif

    always_comb begin
        alu_lo = 32'h0;
`ifdef MULT_EN
        prod = 64'h0;
`endif
        case (alu_op)
            ALU_AND:  alu_lo = rs_val & op_b;
            ALU_OR:   alu_lo = rs_val | op_b;
            ALU_XOR:  alu_lo = rs_val ^ op_b;
            ALU_NOR:  alu_lo = ~(rs_val | op_b);
            ALU_ADD:  alu_lo = rs_val + op_b;
            ALU_SUB:  alu_lo = rs_val - op_b;
            ALU_SLT:  alu_lo = {31'h0, $signed(rs_val) < $signed(op_b)};
            ALU_SLTU: alu_lo = {31'h0, rs_val < op_b};
            ALU_SLL:  alu_lo = op_b << shamt;
            ALU_SRL:  alu_lo = op_b >> shamt;
            ALU_SRA:  alu_lo = $signed(op_b) >>> shamt;
            ALU_LUI:  alu_lo = {imm, 16'h0};
`ifdef MULT_EN
            // Operands widened to 64 bits so the low 64 bits of the product are exact.
            ALU_MULT: begin
                prod   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{op_b[31]}}, op_b});
                alu_lo = prod[31:0];
            end
            ALU_MULTU: begin
                prod   = {32'h0, rs_val} * {32'h0, op_b};
                alu_lo = prod[31:0];
            end
`endif
            default:  alu_lo = 32'h0;
        endcase
    end

    assign alu_zero = (alu_lo == 32'h0);

    // ---------------- writeback ----------------
    logic [31:0] wdata;

    always_comb begin
        wdata = alu_lo;
        case (wb_sel)
`ifdef MULT_EN
            WB_HI:   wdata = hi_q;
            WB_LO:   wdata = lo_q;
`else
            WB_HI:   wdata = 32'h0;
            WB_LO:   wdata = 32'h0;
`endif
            WB_GPIO: wdata = gpio_in;
            default: wdata = alu_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            gpio_out <= 32'h0;
        end else begin
            if (gpr_we && dst != 5'd0) regs[dst] <= wdata;
            if (gpio_we) gpio_out <= rt_val;
        end
    end

`ifdef MULT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else if (hilo_we) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_mips_exec_core.sv
// Self-checking bench for mips_exec_core. Register contents are observed by
// issuing a GPIO-write of the register; the expected value is queued when the
// write is driven and compared against gpio_out after the retiring edge.
module tb_mips_exec_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        alu_zero;

    mips_exec_core dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .alu_zero (alu_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input int rs_i, input int rt_i, input int rd_i,
                                         input int sh, input logic [5:0] fn);
        logic [4:0] a, b, d, s;
        a = rs_i[4:0]; b = rt_i[4:0]; d = rd_i[4:0]; s = sh[4:0];
        return {6'h00, a, b, d, s, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input int rs_i, input int rt_i,
                                         input logic [15:0] im);
        logic [4:0] a, b;
        a = rs_i[4:0]; b = rt_i[4:0];
        return {op, a, b, im};
    endfunction

    // Drive one instruction and let it retire.
    task automatic op(input logic [31:0] ins);
        instr = ins;
        @(posedge clk); #1;
    endtask

    // Drive one instruction and check alu_zero while it is in execute.
    task automatic op_z(input logic [31:0] ins, input string tag, input logic exp_z);
        instr = ins;
        #1;
        chk(tag, {31'h0, alu_zero}, {31'h0, exp_z});
        @(posedge clk); #1;
    endtask

    // GPIO-write of register r; expected value goes through the scoreboard.
    task automatic gw(input int r, input string tag, input logic [31:0] exp);
        sb_t e;
        instr = i_op(6'h10, 4, r, 16'h0);
        sb_q.push_back('{tag, exp});
        @(posedge clk); #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, gpio_out, e.exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        instr   = 32'h0;
        gpio_in = 32'h0;
        @(posedge clk); #1;
        // Reset held with a live instruction: it must be ignored.
        instr = i_op(6'h10, 4, 0, 16'h0);
        @(posedge clk); #1;
        chk("rst_gpio", gpio_out, 32'h0);
        rst = 1'b0;

        // Reset and NOP
        for (int i = 0; i < 4; i++) op_z(32'h0, "nop_zero", 1'b1);
        gw(5, "rst_r5", 32'h0);

        // Immediates and lui
        op_z(i_op(6'h0F, 0, 1, 16'h1234), "lui_nz", 1'b0);
        op(i_op(6'h0D, 1, 1, 16'h5678));
        gw(1, "lui_ori", 32'h12345678);
        op(i_op(6'h08, 0, 2, 16'hFFFF));
        gw(2, "addi_m1", 32'hFFFFFFFF);
        op(i_op(6'h0C, 2, 3, 16'hFFFF));
        gw(3, "andi", 32'h0000FFFF);
        op(i_op(6'h0E, 3, 10, 16'hFF00));
        gw(10, "xori", 32'h000000FF);

        // Compare and shift
        op(i_op(6'h08, 0, 4, 16'h0001));
        op(r_op(2, 4, 5, 0, 6'h2A));
        gw(5, "slt", 32'h1);
        op(r_op(2, 4, 5, 0, 6'h2B));
        gw(5, "sltu", 32'h0);
        op(r_op(0, 2, 6, 4, 6'h03));
        gw(6, "sra", 32'hFFFFFFFF);
        op(r_op(0, 2, 6, 4, 6'h02));
        gw(6, "srl", 32'h0FFFFFFF);
        op(r_op(0, 4, 7, 31, 6'h00));
        gw(7, "sll31", 32'h80000000);
        op(r_op(4, 2, 10, 0, 6'h22));
        gw(10, "sub", 32'h00000002);
        op(r_op(0, 0, 10, 0, 6'h27));
        gw(10, "nor", 32'hFFFFFFFF);
        op(i_op(6'h0A, 4, 10, 16'hFFFF));
        gw(10, "slti", 32'h0);
        op(i_op(6'h0B, 4, 10, 16'hFFFF));
        gw(10, "sltiu", 32'h1);

        // Multiply
        op(i_op(6'h08, 0, 11, 16'hFFFE));
        op(i_op(6'h08, 0, 12, 16'h0003));
        op(i_op(6'h08, 0, 14, 16'h0002));
`ifdef MULT_EN
        op(r_op(11, 12, 0, 0, 6'h18));
        op(r_op(0, 0, 13, 0, 6'h10));
        gw(13, "mult_hi", 32'hFFFFFFFF);
        op(r_op(0, 0, 13, 0, 6'h12));
        gw(13, "mult_lo", 32'hFFFFFFFA);
        op(r_op(2, 14, 0, 0, 6'h19));
        op(r_op(0, 0, 13, 0, 6'h12));
        gw(13, "multu_lo", 32'hFFFFFFFE);
        op(r_op(0, 0, 13, 0, 6'h10));
        gw(13, "multu_hi", 32'h00000001);
`else
        op(i_op(6'h08, 0, 13, 16'h0055));
        op(r_op(11, 12, 0, 0, 6'h18));
        op(r_op(0, 0, 13, 0, 6'h10));
        gw(13, "mfhi_off", 32'h0);
        op(i_op(6'h08, 0, 13, 16'h0055));
        op(r_op(2, 14, 0, 0, 6'h19));
        op(r_op(0, 0, 13, 0, 6'h12));
        gw(13, "mflo_off", 32'h0);
`endif

        // GPIO and $0
        gpio_in = 32'hA5A5A5A5;
        op(i_op(6'h10, 0, 8, 16'h0));
        gpio_in = 32'h0;
        gw(8, "gpio_rd", 32'hA5A5A5A5);
        op_z(i_op(6'h08, 0, 0, 16'h0007), "addi_r0_nz", 1'b0);
        gw(0, "r0_zero", 32'h0);

        // Hazard and illegal encodings
        op(i_op(6'h08, 0, 9, 16'h0005));
        op(r_op(9, 9, 9, 0, 6'h20));
        gw(9, "hazard_add", 32'd10);
        op(i_op(6'h3F, 9, 9, 16'hFFFF));
        op(r_op(9, 9, 9, 0, 6'h3F));
        gw(9, "illegal_keep", 32'd10);
        op(i_op(6'h10, 2, 0, 16'h0));
        chk("gpio_rs2_hold", gpio_out, 32'd10);

        // Reset mid-sequence discards the in-flight write and clears state
        rst = 1'b1;
        op(i_op(6'h08, 0, 9, 16'h0033));
        chk("rst_mid_gpio", gpio_out, 32'h0);
        rst = 1'b0;
        gw(9, "rst_mid_r9", 32'h0);

        if (sb_q.size() != 0) chk("sb_left", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
